// File: rtl/gpio_irq.sv
// gpio_irq: memory-mapped GPIO with set/clear outputs, synchronised and debounced inputs,
// per-pin edge capture into a write-1-to-clear status register driving a level interrupt.
module gpio_irq #(
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 4,
   parameter int OUT_PINS     = 4,
   parameter int IN_PINS      = 6,
   parameter int DEBOUNCE_DIV = 1200
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [ADDRESS_BITS-1:0] ADDRESS,
   input  logic [BITS-1:0]         DATA_IN,
   output logic [BITS-1:0]         DATA_OUT,
   input  logic                    WR,
   output logic [OUT_PINS-1:0]     PINS,
   input  logic [IN_PINS-1:0]      INPUT_PINS,
   output logic                    IRQ
);
   localparam int CW = DEBOUNCE_DIV > 1 ? $clog2(DEBOUNCE_DIV) : 1;
   localparam logic [ADDRESS_BITS-1:0] A_OUT  = ADDRESS_BITS'(0);
   localparam logic [ADDRESS_BITS-1:0] A_IN   = ADDRESS_BITS'(1);
   localparam logic [ADDRESS_BITS-1:0] A_SET  = ADDRESS_BITS'(2);
   localparam logic [ADDRESS_BITS-1:0] A_CLR  = ADDRESS_BITS'(3);
   localparam logic [ADDRESS_BITS-1:0] A_REN  = ADDRESS_BITS'(4);
   localparam logic [ADDRESS_BITS-1:0] A_FEN  = ADDRESS_BITS'(5);
   localparam logic [ADDRESS_BITS-1:0] A_STAT = ADDRESS_BITS'(6);

   logic [CW-1:0]       cnt;
   logic                tick;
   logic [OUT_PINS-1:0] out_q, d_out;
   logic [IN_PINS-1:0]  d_in, sync_a, sync_b, samp, deb, deb_prev;
   logic [IN_PINS-1:0]  rise_en, fall_en, status, rise, fall, w1c, agree;
   logic                unused_data;

   assign d_out       = DATA_IN[OUT_PINS-1:0];
   assign d_in        = DATA_IN[IN_PINS-1:0];
   assign unused_data = ^DATA_IN;
   assign tick        = cnt == CW'(DEBOUNCE_DIV - 1);
   assign agree       = ~(sync_b ^ samp);
   assign rise        = deb & ~deb_prev;
   assign fall        = ~deb & deb_prev;
   assign w1c         = (WR && ADDRESS == A_STAT) ? d_in : '0;
   assign PINS        = out_q;
   assign IRQ         = |status;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt      <= '0;
         sync_a   <= '0;
         sync_b   <= '0;
         samp     <= '0;
         deb      <= '0;
         deb_prev <= '0;
      end else begin
         cnt      <= tick ? '0 : cnt + 1'b1;
         sync_a   <= INPUT_PINS;
         sync_b   <= sync_a;
         deb_prev <= deb;
         if (tick) begin
            samp <= sync_b;
            // only pins whose last two tick samples agree may move
            deb  <= (agree & sync_b) | (~agree & deb);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_q   <= '0;
         rise_en <= '0;
         fall_en <= '0;
         status  <= '0;
      end else begin
         status <= (status & ~w1c) | (rise & rise_en) | (fall & fall_en);
         if (WR) begin
            out_q   <= ADDRESS == A_OUT ? d_out :
                       ADDRESS == A_SET ? out_q | d_out :
                       ADDRESS == A_CLR ? out_q & ~d_out : out_q;
            rise_en <= ADDRESS == A_REN ? d_in : rise_en;
            fall_en <= ADDRESS == A_FEN ? d_in : fall_en;
         end
      end
   end

   always_comb begin
      DATA_OUT = ADDRESS == A_OUT  ? BITS'(out_q)   :
                 ADDRESS == A_IN   ? BITS'(deb)     :
                 ADDRESS == A_REN  ? BITS'(rise_en) :
                 ADDRESS == A_FEN  ? BITS'(fall_en) :
                 ADDRESS == A_STAT ? BITS'(status)  : '0;
   end
endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised general-purpose I/O block for the peripheral bus: a configurable-width output port with set/clear access, and a configurable-width input port with two-stage synchronisation. Inputs also get a prescaled debounce filter and per-pin rising/falling edge capture. Edge events latch into a write-1-to-clear status register, and their OR drives a level interrupt to the interrupt controller. It sits on the same ADDRESS/DATA_IN/DATA_OUT/WR bus as the other memory-mapped peripherals.

## Interface
- BITS, 16, bus data width
- ADDRESS_BITS, 4, register address width
- OUT_PINS, 4, number of output pins (1..BITS)
- IN_PINS, 6, number of input pins (1..BITS)
- DEBOUNCE_DIV, 1200, debounce sample period in CLK cycles (1 = sample every cycle; 1200 = 100 us at 12 MHz)
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- ADDRESS  in  ADDRESS_BITS  register select
- DATA_IN  in  BITS  write data
- DATA_OUT  out  BITS  read data, combinational from ADDRESS and registers
- WR  in  1  write strobe, one write per cycle it is high
- PINS  out  OUT_PINS  output pins, driven directly from the output register
- INPUT_PINS  in  IN_PINS  asynchronous input pins
- IRQ  out  1  level interrupt, high while any status bit is set

## Operation
- Register map (word addresses; unused read bits are 0; unmapped addresses read 0 and ignore writes):
  - 0 OUT (RW): write loads PINS from DATA_IN[OUT_PINS-1:0]; read returns current PINS.
  - 1 IN (RO): debounced input value.
  - 2 SET (WO): OUT <= OUT | DATA_IN.
  - 3 CLR (WO): OUT <= OUT & ~DATA_IN.
  - 4 RISE_EN (RW): per-input rising-edge capture enable.
  - 5 FALL_EN (RW): per-input falling-edge capture enable.
  - 6 STATUS (R/W1C): captured edges; writing 1 clears that bit, writing 0 has no effect.
- Input path per pin:
  - Two-flop synchroniser sync_a -> sync_b.
  - Shared prescaler counts 0..DEBOUNCE_DIV-1 and asserts tick when count == DEBOUNCE_DIV-1, then wraps to 0.
  - On tick: samp <= sync_b; if sync_b == samp, then deb <= sync_b.
  - deb therefore changes only after two consecutive tick samples agree.
- Edge capture:
  - deb_prev <= deb every cycle.
  - rise = deb & ~deb_prev; fall = ~deb & deb_prev.
  - STATUS <= (STATUS & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - A new edge in the same cycle as a W1C write of that bit leaves the bit set (set wins).
  - Changing RISE_EN/FALL_EN never clears STATUS.
- IRQ = |STATUS (combinational from the STATUS register).
- DATA_IN bits above OUT_PINS / IN_PINS are ignored on write.

## Timing
- Reset (RST high at a rising edge):
  - PINS, OUT, RISE_EN, FALL_EN, and STATUS clear to 0, so IRQ is 0.
  - sync_a, sync_b, samp, deb, and deb_prev clear to 0.
  - The prescaler clears to 0.
  - Reset mid-debounce discards all partial state.
  - A write in the same cycle as RST is ignored.
- Writes: register updates at the CLK edge where WR is high; PINS changes one cycle after the WR edge.
- Reads: DATA_OUT is valid in the same cycle as ADDRESS, with no wait states.
- Input latency with DEBOUNCE_DIV=1, input stable from before edge 1:
  - sync_b is new after edge 2.
  - samp is new after edge 3.
  - deb is new after edge 4; IN is readable after edge 4.
  - STATUS and IRQ are set after edge 5.
- With general DIV: deb updates on the second tick after sync_b settles, i.e. 2 + DIV to 2 + 2·DIV cycles.
- A glitch shorter than one tick period never changes deb.
- Prescaler wraps freely and is not resynchronised to input activity.
- After reset with an input held high, deb rises once; STATUS sets only if RISE_EN was enabled by then.

## Test plan
- Reset: drive RST for 2 cycles with INPUT_PINS=6'h3F -> PINS=0, IRQ=0, and every readable address returns 0 immediately after reset.
- Output access (OUT_PINS=4), each write on its own WR cycle:
  - write OUT=16'h0005 -> PINS=4'h5 next cycle;
  - SET 16'h000A -> PINS=4'hF;
  - CLR 16'h0003 -> PINS=4'hC;
  - reading address 0 returns 16'h000C.
- Debounce (DEBOUNCE_DIV=4):
  - pulse INPUT_PINS[2] high for 3 cycles -> IN stays 0;
  - hold it high -> IN reads 16'h0004 within 2+8 cycles and no earlier than 2+4.
- Edge IRQ (DIV=1):
  - RISE_EN=16'h0001, then raise pin 0 -> STATUS=16'h0001 and IRQ=1 five edges after the change;
  - lowering the pin with FALL_EN=0 does not set further bits.
- W1C race (DIV=1):
  - write STATUS=16'h0001 in the exact cycle a new rising edge on pin 0 is captured -> STATUS stays 16'h0001 and IRQ stays high;
  - a later W1C with no edge -> STATUS=0, IRQ=0.
- Unmapped access: write 16'hFFFF to address 4'hF -> no register changes; reading 4'hF returns 0.
